// File: rtl/simple_rsp_bfm_pkg.sv
// simple_rsp_bfm_pkg: shared types and widths for the req/ack responder BFM
package simple_rsp_bfm_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, ACK, WAIT_DROP} rsp_state_e;
    localparam int DATA_W = 8;
    localparam int STALL_W = 16;
endpackage

// File: rtl/simple_rsp_fifo.sv
// simple_rsp_fifo: DEPTH-entry sync FIFO (push/din in, pop/dout out, full/empty/count status), head reads 0 when empty
module simple_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [AW:0] wp, rp;
    logic [W-1:0] mem [DEPTH];
    logic do_push, do_pop;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign count = CW'(wp - rp);
    assign dout = empty ? '0 : mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/simple_rsp_bfm.sv
// simple_rsp_bfm: req/ack responder (req_i/data_i in, delayed ack_o pulse out) buffering captures for a valid/ready drain (rdata_o/rvalid_o/rready_i, count_o, stall_cnt_o)
module simple_rsp_bfm
  import simple_rsp_bfm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DLY_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ack_o,
  input  logic [DLY_W-1:0]           ack_delay_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       rvalid_o,
  input  logic                       rready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [STALL_W-1:0]         stall_cnt_o
);
  rsp_state_e state, state_n;
  logic [DLY_W-1:0] cnt, cnt_n;
  logic [STALL_W-1:0] stall_n;
  logic ack_n, push, full, empty;
  simple_rsp_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(data_i),
    .pop(rready_i),
    .dout(rdata_o),
    .full(full),
    .empty(empty),
    .count(count_o)
  );
  assign rvalid_o = !empty;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ack_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ack_o <= ack_n;
      stall_cnt_o <= stall_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ack_n = 1'b0;
    stall_n = stall_cnt_o;
    push = 1'b0;
    case (state)
      IDLE: begin
        push = req_i && !full;
        state_n = push ? DELAY : IDLE;
        cnt_n = push ? ack_delay_i : cnt;
        stall_n = (req_i && full && stall_cnt_o != '1) ? stall_cnt_o + 1'b1 : stall_cnt_o;
      end
      DELAY: begin
        ack_n = cnt == '0;
        state_n = ack_n ? ACK : DELAY;
        cnt_n = ack_n ? cnt : cnt - 1'b1;
      end
      ACK: state_n = WAIT_DROP;
      WAIT_DROP: state_n = req_i ? WAIT_DROP : IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_simple_rsp_bfm.sv
// tb_simple_rsp_bfm: directed-vector bench for simple_rsp_bfm covering latency, backpressure, wrap and reset recovery
module tb_simple_rsp_bfm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_i = 1'b0;
    logic [7:0] data_i = '0;
    logic ack_o;
    logic [3:0] ack_delay_i = '0;
    logic [7:0] rdata_o;
    logic rvalid_o;
    logic rready_i = 1'b0;
    logic [2:0] count_o;
    logic [15:0] stall_cnt_o;
    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int lat, base;
    simple_rsp_bfm #(.DEPTH(4), .DLY_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req_i),
        .data_i(data_i),
        .ack_o(ack_o),
        .ack_delay_i(ack_delay_i),
        .rdata_o(rdata_o),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .count_o(count_o),
        .stall_cnt_o(stall_cnt_o)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (ack_o) ack_cnt++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] d, input logic [3:0] dly, input int hold, output int n);
        n = 0;
        req_i = 1'b1;
        data_i = d;
        ack_delay_i = dly;
        do begin
            tick();
            n++;
        end while (!ack_o && n < 60);
        check("ack_seen", ack_o, 1);
        tick();
        check("ack_pulse", ack_o, 0);
        repeat (hold) tick();
        req_i = 1'b0;
        data_i = '0;
        tick();
    endtask
    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, rdata_o, exp);
        check("rvalid", rvalid_o, 1);
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
    endtask
    initial begin
        repeat (3) tick();
        check("rst_ack", ack_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_count", count_o, 0);
        check("rst_stall", stall_cnt_o, 0);
        rst_n = 1'b1;
        tick();
        send(8'hA5, 4'd0, 0, lat);
        check("d0_lat", lat, 2);
        check("d0_count", count_o, 1);
        check("d0_acks", ack_cnt, 1);
        pop_check("d0_data", 8'hA5);
        check("d0_empty", count_o, 0);
        send(8'h3C, 4'd3, 4, lat);
        check("d3_lat", lat, 5);
        check("d3_single", count_o, 1);
        check("d3_acks", ack_cnt, 2);
        pop_check("d3_data", 8'h3C);
        req_i = 1'b1;
        data_i = 8'h11;
        ack_delay_i = 4'd2;
        tick();
        ack_delay_i = 4'd7;
        tick();
        tick();
        check("chg_early", ack_o, 0);
        tick();
        check("chg_ack_n3", ack_o, 1);
        tick();
        check("chg_pulse", ack_o, 0);
        req_i = 1'b0;
        tick();
        send(8'h22, 4'd7, 0, lat);
        check("chg_next_lat", lat, 9);
        pop_check("chg_d0", 8'h11);
        pop_check("chg_d1", 8'h22);
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 4'd0, 0, lat);
            check("bp_lat", lat, 2);
        end
        check("bp_full", count_o, 4);
        base = ack_cnt;
        req_i = 1'b1;
        data_i = 8'h05;
        ack_delay_i = 4'd0;
        repeat (5) tick();
        check("bp_noack", ack_cnt, base);
        check("bp_stall", stall_cnt_o, 5);
        check("bp_count", count_o, 4);
        check("bp_head", rdata_o, 8'h01);
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
        check("bp_popfirst", count_o, 3);
        check("bp_stall_pop", stall_cnt_o, 6);
        tick();
        check("bp_capture", count_o, 4);
        tick();
        check("bp_ack", ack_o, 1);
        tick();
        req_i = 1'b0;
        tick();
        check("bp_acks", ack_cnt, base + 1);
        for (int i = 2; i <= 5; i++) pop_check("bp_order", 8'(i));
        send(8'h10, 4'd0, 0, lat);
        send(8'h20, 4'd0, 0, lat);
        check("pp_pre", count_o, 2);
        rready_i = 1'b1;
        req_i = 1'b1;
        data_i = 8'h30;
        tick();
        rready_i = 1'b0;
        check("pp_count", count_o, 2);
        check("pp_head", rdata_o, 8'h20);
        tick();
        check("pp_ack", ack_o, 1);
        tick();
        req_i = 1'b0;
        tick();
        pop_check("pp_d0", 8'h20);
        pop_check("pp_d1", 8'h30);
        for (int i = 0; i < 10; i += 2) begin
            send(8'h40 + 8'(i), 4'd0, 0, lat);
            send(8'h41 + 8'(i), 4'd0, 0, lat);
            pop_check("wrap_a", 8'h40 + 8'(i));
            pop_check("wrap_b", 8'h41 + 8'(i));
        end
        check("wrap_empty", rvalid_o, 0);
        req_i = 1'b1;
        data_i = 8'h77;
        ack_delay_i = 4'd5;
        tick();
        tick();
        check("mr_pre", count_o, 1);
        rst_n = 1'b0;
        ack_delay_i = 4'd1;
        tick();
        check("mr_ack", ack_o, 0);
        check("mr_count", count_o, 0);
        check("mr_rvalid", rvalid_o, 0);
        check("mr_stall", stall_cnt_o, 0);
        base = ack_cnt;
        rst_n = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ack_o && lat < 60);
        check("mr_lat", lat, 3);
        tick();
        check("mr_pulse", ack_o, 0);
        req_i = 1'b0;
        repeat (3) tick();
        check("mr_once", ack_cnt, base + 1);
        check("mr_count1", count_o, 1);
        pop_check("mr_data", 8'h77);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
